// File: rtl/tag_compare_nway_if.sv
// Request, AXI R and result channels of the N-way DRAM-cache tag comparator.
interface tag_compare_nway_if #(
    parameter int DATA_W = 72,
    parameter int TAG_W  = 56,
    parameter int WAYS   = 4,
    parameter int WAY_W  = 3,
    parameter int ID_W   = 8
);
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic                   req_write_i;
    logic [TAG_W-1:0]       req_tag_i;
    logic [ID_W-1:0]        req_id_i;
    logic                   rvalid_i;
    logic                   rready_o;
    logic [WAYS*DATA_W-1:0] rdata_i;
    logic [WAYS*TAG_W-1:0]  rtag_i;
    logic [WAYS-1:0]        rtag_vld_i;
    logic                   res_valid_o;
    logic                   res_ready_i;
    logic [1:0]             res_class_o;
    logic [WAY_W-1:0]       res_way_o;
    logic [DATA_W-1:0]      res_data_o;
    logic [ID_W-1:0]        res_id_o;

    modport master (
        output req_valid_i, req_write_i, req_tag_i, req_id_i,
        output rvalid_i, rdata_i, rtag_i, rtag_vld_i, res_ready_i,
        input  req_ready_o, rready_o, res_valid_o, res_class_o, res_way_o, res_data_o, res_id_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_tag_i, req_id_i,
        input  rvalid_i, rdata_i, rtag_i, rtag_vld_i, res_ready_i,
        output req_ready_o, rready_o, res_valid_o, res_class_o, res_way_o, res_data_o, res_id_o
    );
endinterface

// File: rtl/tag_compare_nway.sv
// N-way tag comparator: owns the pending-request queue, classifies each R beat
// against the head request, picks a victim way on misses and counts hits/misses.
module tag_compare_nway #(
    parameter int DATA_W    = 72,
    parameter int TAG_W     = 56,
    parameter int WAYS      = 4,
    parameter int WAY_W     = 3,
    parameter int ID_W      = 8,
    parameter int REQ_DEPTH = 8,
    parameter int CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    tag_compare_nway_if.slave  bus,
    output logic               multi_hit_o,
    input  logic               cnt_clr_i,
    output logic [CNT_W-1:0]   cnt_hit_o,
    output logic [CNT_W-1:0]   cnt_miss_o
);
    localparam int PTR_W = $clog2(REQ_DEPTH);

    logic [TAG_W-1:0]     q_tag [REQ_DEPTH];
    logic [ID_W-1:0]      q_id  [REQ_DEPTH];
    logic [REQ_DEPTH-1:0] q_wr;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       count;
    logic                 q_full, q_empty, push, pop;

    logic [TAG_W-1:0]     head_tag;
    logic [WAYS-1:0]      match;
    logic                 hit, multi, any_free, rr_adv;
    logic [WAY_W-1:0]     hit_way, free_way, sel_way, rr_ptr;
    logic [DATA_W-1:0]    sel_data;

    logic                 vld_p1;
    logic [1:0]           class_p1;
    logic [WAY_W-1:0]     way_p1;
    logic [DATA_W-1:0]    data_p1;
    logic [ID_W-1:0]      id_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign q_full  = (count == (PTR_W+1)'(REQ_DEPTH));
    assign q_empty = (count == '0);
    assign push    = bus.req_valid_i && !q_full;
    assign bus.req_ready_o = !q_full;
    assign bus.rready_o    = !q_empty && (!vld_p1 || bus.res_ready_i);
    assign pop     = bus.rvalid_i && bus.rready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + (PTR_W+1)'(1);
            else if (!push && pop) count <= count - (PTR_W+1)'(1);
        end
    end

    // Queue storage carries no control state, so it is left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            q_tag[wr_ptr] <= bus.req_tag_i;
            q_id[wr_ptr]  <= bus.req_id_i;
            q_wr[wr_ptr]  <= bus.req_write_i;
        end
    end

    assign head_tag = q_tag[rd_ptr];

    // Descending scan leaves the lowest matching / lowest invalid way selected.
    always_comb begin
        match    = '0;
        hit_way  = '0;
        free_way = '0;
        any_free = 1'b0;
        for (int k = WAYS - 1; k >= 0; k--) begin
            match[k] = bus.rtag_vld_i[k] && (bus.rtag_i[k*TAG_W +: TAG_W] == head_tag);
            if (match[k]) hit_way = WAY_W'(k);
            if (!bus.rtag_vld_i[k]) begin
                free_way = WAY_W'(k);
                any_free = 1'b1;
            end
        end
    end

    assign hit     = |match;
    assign multi   = |(match & (match - WAYS'(1)));
    assign sel_way = hit ? hit_way : (any_free ? free_way : rr_ptr);
    assign rr_adv  = pop && !hit && !any_free;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < WAYS; k++) begin
            if (sel_way == WAY_W'(k)) sel_data = bus.rdata_i[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (rr_adv) begin
            rr_ptr <= (rr_ptr == WAY_W'(WAYS - 1)) ? '0 : rr_ptr + WAY_W'(1);
        end
    end

    // ---- stage p1: registered result, held until the reordering buffer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            class_p1    <= '0;
            way_p1      <= '0;
            data_p1     <= '0;
            id_p1       <= '0;
            multi_hit_o <= 1'b0;
        end else begin
            multi_hit_o <= pop && multi;
            if (pop) begin
                vld_p1   <= 1'b1;
                class_p1 <= {q_wr[rd_ptr], !hit};
                way_p1   <= sel_way;
                data_p1  <= sel_data;
                id_p1    <= q_id[rd_ptr];
            end else if (bus.res_ready_i) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_hit_o  <= '0;
            cnt_miss_o <= '0;
        end else if (cnt_clr_i) begin
            cnt_hit_o  <= '0;
            cnt_miss_o <= '0;
        end else if (pop) begin
            if (hit) cnt_hit_o  <= sat_inc(cnt_hit_o);
            else     cnt_miss_o <= sat_inc(cnt_miss_o);
        end
    end

    assign bus.res_valid_o = vld_p1;
    assign bus.res_class_o = class_p1;
    assign bus.res_way_o   = way_p1;
    assign bus.res_data_o  = data_p1;
    assign bus.res_id_o    = id_p1;
endmodule
